imem_boot_arbiter: RTL and testbench
====================================

Name: imem_boot_arbiter

Overview:
- Owns the single-port instruction memory and shares it between the core's fetch stage and a UART program loader.
- Sequences boot: holds the core in stall/reset while a program is written in, then hands the memory to fetch.
- Supports a runtime reload request that drains any outstanding fetch and returns the memory to the loader.
- Sits between the fetch stage (PC, stall, instruction) and the program memory instance.

Parameters:
- ADDR_W, 14, word-address width of instruction memory (16K words).
- TIMEOUT, 1000000, idle cycles in LOAD with no accepted beat before forcing RUN; must be >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- boot_mode  in  1  sampled in IDLE: 1 = wait for loader, 0 = run the resident program.
- reload_req  in  1  single-cycle pulse; honoured only in RUN.
- ld_valid  in  1  loader beat valid.
- ld_ready  out  1  arbiter accepts the beat this cycle.
- ld_addr  in  ADDR_W  word address of the beat.
- ld_data  in  32  instruction word to write.
- ld_last  in  1  qualifies the final beat of a load.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch byte PC; word index = if_addr[ADDR_W+1:2].
- if_inst  out  32  fetched instruction.
- if_valid  out  1  if_inst valid this cycle.
- cpu_hold  out  1  stall to the fetch stage.
- cpu_run  out  1  core release; 0 keeps the core in reset.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; 1-cycle synchronous latency.
- state  out  3  debug: IDLE=0, LOAD=1, FLUSH=2, RUN=3, DRAIN=4.
- load_count  out  ADDR_W+1  beats accepted in the current load.

Behaviour:
- Reset, while rst=0 (asynchronous):
  - state=IDLE; timeout counter=0; load_count=0; read-pending flag=0.
  - ld_ready=0, if_valid=0, cpu_hold=1, cpu_run=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_inst=0.
- IDLE: one cycle after reset release. Next state is LOAD if boot_mode=1, otherwise RUN.
- Entering LOAD clears load_count and the timeout counter.
- LOAD:
  - ld_ready=1 combinationally.
  - A beat is accepted when ld_valid=1 (ld_valid & ld_ready).
  - On an accepted beat:
    - mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data, all in the same cycle.
    - load_count increments, saturating at all-ones.
    - Timeout counter clears.
  - With no accepted beat, the timeout counter increments.
  - Accepted beat with ld_last=1 -> FLUSH.
  - Counter reaching TIMEOUT-1 with no beat -> RUN.
  - An accepted beat always wins over a timeout in the same cycle.
- FLUSH:
  - One cycle with mem_en=0 and ld_ready=0; this guarantees write-to-read separation.
  - Next state is RUN.
- RUN:
  - cpu_hold=0 and cpu_run=1, both registered (asserted the cycle after the transition).
  - ld_ready=0; loader beats are ignored (no write, no count).
  - mem_en=if_req, mem_we=0, mem_addr=if_addr[ADDR_W+1:2]. if_addr[1:0] and the upper bits are ignored.
  - if_valid=1 exactly one cycle after a cycle with if_req=1, with if_inst=mem_rdata. Back-to-back requests give back-to-back valids.
  - reload_req=1 -> DRAIN. A fetch issued in that same cycle is still performed.
- DRAIN:
  - cpu_hold=1 and cpu_run=0, registered.
  - No new memory access.
  - A read issued in the last RUN cycle completes here (if_valid=1 for one cycle).
  - Next state is LOAD, which clears load_count.
- Outside RUN and DRAIN:
  - if_req is ignored and if_valid=0.
  - cpu_hold=1 and cpu_run=0 in IDLE, LOAD and FLUSH.
- reload_req outside RUN is ignored.
- Mid-operation reset (rst=0 in any state):
  - Immediately forces the IDLE outputs above.
  - Any in-flight write is abandoned; mem_we drops asynchronously.

Test Plan:
- Reset with boot_mode=1, then 3 beats (addr 0,1,2; data 0x00000013, 0x00100093, 0x00208113; last on beat 3) -> three writes, load_count=3, FLUSH for 1 cycle, cpu_run=1 two cycles after the last beat.
- RUN with if_req=1 and if_addr=0x4, 0x8 on consecutive cycles -> if_valid on the next two cycles with if_inst=0x00100093 then 0x00208113.
- boot_mode=1, TIMEOUT=8, no ld_valid -> RUN entered after 8 LOAD cycles, load_count=0. Repeat with a beat landing on the timeout cycle -> beat written and stays in LOAD.
- RUN, reload_req and if_req (if_addr=0x0) in the same cycle -> DRAIN with if_valid=1 and if_inst=0x00000013, then LOAD with cpu_hold=1, cpu_run=0, load_count=0.
- RUN, ld_valid=1 with ld_addr=5 -> ld_ready=0, mem_we never asserted, memory word 5 unchanged.
- rst pulled low mid-LOAD during an accepted beat -> mem_we=0 and state=0 without waiting for a clock edge; after release, boot_mode=0 goes to RUN.

Source files
------------

// File: rtl/imem_boot_arbiter.sv
// Instruction-memory arbiter: boot loader writes the program, then fetch owns the port.
// Runtime reloads drain the outstanding fetch before handing the memory back to the loader.
module imem_boot_arbiter #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_mode,
    input  logic              reload_req,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_inst,
    output logic              if_valid,
    output logic              cpu_hold,
    output logic              cpu_run,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        state,
    output logic [ADDR_W:0]   load_count
);

    localparam int unsigned     TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            run_q, run_d;
    logic            hold_q, hold_d;

    // Only the word index of the fetch PC reaches the memory.
    logic unused_if_bits;
    assign unused_if_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            run_q   <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            run_q   <= run_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        pend_d    = 1'b0;
        ld_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (boot_mode) begin
                    state_d = S_LOAD;
                    tmo_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                // An accepted beat takes priority over an expiring timeout.
                if (ld_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_data;
                    cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    tmo_d     = '0;
                    if (ld_last) begin
                        state_d = S_FLUSH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    state_d = S_RUN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                mem_en   = if_req;
                mem_addr = if_addr[ADDR_W+1:2];
                pend_d   = if_req;
                if (reload_req) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_LOAD;
                tmo_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered from the next state so the core is released together with RUN.
        run_d  = (state_d == S_RUN);
        hold_d = (state_d != S_RUN);
    end

    assign state      = state_q;
    assign load_count = cnt_q;
    assign if_valid   = pend_q;
    assign if_inst    = pend_q ? mem_rdata : '0;
    assign cpu_run    = run_q;
    assign cpu_hold   = hold_q;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Randomized bench for imem_boot_arbiter: a cycle-level behavioural model with a shadow
// memory predicts every output; directed sequences pin the model with literal values.
module tb_imem_boot_arbiter;

    localparam int unsigned AW   = 4;
    localparam int unsigned TMO  = 8;
    localparam int unsigned CMAX = (1 << (AW + 1)) - 1;

    logic          clk;
    logic          rst;
    logic          boot_mode, reload_req, ld_valid, ld_last, if_req;
    logic          ld_ready, if_valid, cpu_hold, cpu_run, mem_en, mem_we;
    logic [AW-1:0] ld_addr, mem_addr;
    logic [31:0]   ld_data, if_addr, if_inst, mem_wdata, mem_rdata;
    logic [2:0]    state;
    logic [AW:0]   load_count;

    int compared   = 0;
    int mismatched = 0;

    imem_boot_arbiter #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .boot_mode  (boot_mode),
        .reload_req (reload_req),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_inst    (if_inst),
        .if_valid   (if_valid),
        .cpu_hold   (cpu_hold),
        .cpu_run    (cpu_run),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .state      (state),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pre_word(int unsigned i);
        return 32'hC0DE0000 ^ (i * 32'h00009E37);
    endfunction

    // Single-port synchronous RAM with one-cycle read latency.
    logic        ram_init;
    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= pre_word(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: phase 0..4 as the debug encoding, idle = LOAD cycles without a beat.
    int          m_state, m_idle, m_count;
    bit          m_pend;
    logic [31:0] m_pend_val;
    logic [31:0] shadow [16];

    initial begin
        m_state = 0; m_idle = 0; m_count = 0; m_pend = 0; m_pend_val = '0;
        forever begin
            bit          np;
            logic [31:0] pv;
            @(posedge clk);
            if (ram_init) begin
                for (int i = 0; i < 16; i++) shadow[i] = pre_word(i);
            end
            np = 0;
            pv = '0;
            if (!rst) begin
                m_state = 0; m_idle = 0; m_count = 0;
            end else begin
                case (m_state)
                    0: if (boot_mode) begin m_state = 1; m_count = 0; m_idle = 0; end
                       else m_state = 3;
                    1: if (ld_valid) begin
                           shadow[ld_addr] = ld_data;
                           if (m_count < int'(CMAX)) m_count++;
                           m_idle = 0;
                           if (ld_last) m_state = 2;
                       end else begin
                           m_idle++;
                           if (m_idle == int'(TMO)) begin m_state = 3; m_idle = 0; end
                       end
                    2: m_state = 3;
                    3: begin
                           if (if_req) begin
                               np = 1;
                               pv = shadow[if_addr[AW+1:2]];
                           end
                           if (reload_req) m_state = 4;
                       end
                    default: begin m_state = 1; m_count = 0; m_idle = 0; end
                endcase
            end
            m_pend     = np;
            m_pend_val = pv;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst.state", 64'(state), 64'd0);
                chk("rst.ld_ready", 64'(ld_ready), 64'd0);
                chk("rst.if_valid", 64'(if_valid), 64'd0);
                chk("rst.if_inst", 64'(if_inst), 64'd0);
                chk("rst.cpu_hold", 64'(cpu_hold), 64'd1);
                chk("rst.cpu_run", 64'(cpu_run), 64'd0);
                chk("rst.mem_en", 64'(mem_en), 64'd0);
                chk("rst.mem_we", 64'(mem_we), 64'd0);
                chk("rst.mem_addr", 64'(mem_addr), 64'd0);
                chk("rst.mem_wdata", 64'(mem_wdata), 64'd0);
                chk("rst.load_count", 64'(load_count), 64'd0);
            end else begin
                bit e_en, e_we, e_run;
                e_run = (m_state == 3);
                e_we  = (m_state == 1) && ld_valid;
                e_en  = e_we || (e_run && if_req);
                chk("state", 64'(state), 64'(m_state));
                chk("ld_ready", 64'(ld_ready), 64'(m_state == 1));
                chk("cpu_run", 64'(cpu_run), 64'(e_run));
                chk("cpu_hold", 64'(cpu_hold), 64'(!e_run));
                chk("if_valid", 64'(if_valid), 64'(m_pend));
                chk("if_inst", 64'(if_inst), m_pend ? 64'(m_pend_val) : 64'd0);
                chk("mem_en", 64'(mem_en), 64'(e_en));
                chk("mem_we", 64'(mem_we), 64'(e_we));
                chk("load_count", 64'(load_count), 64'(m_count));
                if (e_en) chk("mem_addr", 64'(mem_addr), e_we ? 64'(ld_addr) : 64'(if_addr[AW+1:2]));
                if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(ld_data));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [AW-1:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_last  = last;
    endtask

    initial begin
        int unsigned n;
        int unsigned pv;
        rst = 1'b0; boot_mode = 1'b0; reload_req = 1'b0; ld_valid = 1'b0; ld_addr = '0;
        ld_data = '0; ld_last = 1'b0; if_req = 1'b0; if_addr = '0; ram_init = 1'b1;
        step(); step();
        ram_init = 1'b0;
        @(negedge clk);
        chk("lit.reset_state", 64'(state), 64'd0);
        chk("lit.reset_hold", 64'(cpu_hold), 64'd1);
        chk("lit.reset_if_inst", 64'(if_inst), 64'd0);

        // Boot load of three beats.
        boot_mode = 1'b1;
        step(); rst = 1'b1;
        step();
        beat(0, 32'h00000013, 1'b0);
        @(negedge clk);
        chk("lit.beat0_we", 64'(mem_we), 64'd1);
        step(); beat(1, 32'h00100093, 1'b0);
        step(); beat(2, 32'h00208113, 1'b1);
        @(negedge clk);
        chk("lit.beat2_wdata", 64'(mem_wdata), 64'h00208113);
        step(); ld_valid = 1'b0; ld_last = 1'b0;
        @(negedge clk);
        chk("lit.flush_state", 64'(state), 64'd2);
        chk("lit.flush_en", 64'(mem_en), 64'd0);
        chk("lit.load_count3", 64'(load_count), 64'd3);
        step();
        @(negedge clk);
        chk("lit.run_after2", 64'(cpu_run), 64'd1);

        // Back-to-back fetches.
        if_req = 1'b1; if_addr = 32'h4;
        step(); if_addr = 32'h8;
        @(negedge clk);
        chk("lit.fetch1_valid", 64'(if_valid), 64'd1);
        chk("lit.fetch1_inst", 64'(if_inst), 64'h00100093);
        step(); if_req = 1'b0;
        @(negedge clk);
        chk("lit.fetch2_inst", 64'(if_inst), 64'h00208113);
        step();
        @(negedge clk);
        chk("lit.fetch_idle", 64'(if_valid), 64'd0);

        // Loader beats ignored in RUN.
        beat(5, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("lit.run_ready", 64'(ld_ready), 64'd0);
        chk("lit.run_we", 64'(mem_we), 64'd0);
        step(); ld_valid = 1'b0; if_req = 1'b1; if_addr = 32'hF0000016;
        step(); if_req = 1'b0;
        @(negedge clk);
        chk("lit.word5_kept", 64'(if_inst), 64'(pre_word(5)));

        // Reload with a fetch in the same cycle.
        if_req = 1'b1; if_addr = 32'h0; reload_req = 1'b1;
        step(); if_req = 1'b0; reload_req = 1'b0;
        @(negedge clk);
        chk("lit.drain_state", 64'(state), 64'd4);
        chk("lit.drain_valid", 64'(if_valid), 64'd1);
        chk("lit.drain_inst", 64'(if_inst), 64'h00000013);
        step();
        @(negedge clk);
        chk("lit.reload_state", 64'(state), 64'd1);
        chk("lit.reload_run", 64'(cpu_run), 64'd0);
        chk("lit.reload_count", 64'(load_count), 64'd0);

        // Timeout with no beats.
        n = 0;
        while (state == 3'd1 && n < 20) begin
            n++;
            step();
            @(negedge clk);
        end
        chk("lit.timeout_cycles", 64'(n), 64'd8);
        chk("lit.timeout_state", 64'(state), 64'd3);

        // Beat on the timeout cycle keeps LOAD.
        step(); reload_req = 1'b1;
        step(); reload_req = 1'b0;
        step();
        repeat (7) step();
        beat(3, 32'h0BADF00D, 1'b0);
        @(negedge clk);
        chk("lit.tmo_beat_we", 64'(mem_we), 64'd1);
        step(); ld_valid = 1'b0;
        @(negedge clk);
        chk("lit.tmo_beat_state", 64'(state), 64'd1);
        chk("lit.tmo_beat_count", 64'(load_count), 64'd1);

        // Saturation of load_count.
        for (int i = 0; i < 35; i++) begin
            beat(AW'(i), $urandom, 1'b0);
            step();
        end
        ld_valid = 1'b0;
        @(negedge clk);
        chk("lit.count_sat", 64'(load_count), 64'(CMAX));
        beat(0, 32'h00000013, 1'b1);
        step(); ld_valid = 1'b0; ld_last = 1'b0;
        @(negedge clk);
        chk("lit.sat_flush", 64'(state), 64'd2);

        // Asynchronous reset during an accepted beat.
        step(); reload_req = 1'b1;
        step(); reload_req = 1'b0;
        step();
        beat(7, 32'h12345678, 1'b0);
        @(negedge clk);
        chk("lit.pre_rst_we", 64'(mem_we), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("lit.async_we", 64'(mem_we), 64'd0);
        chk("lit.async_state", 64'(state), 64'd0);
        boot_mode = 1'b0; ld_valid = 1'b0;
        step(); rst = 1'b1;
        @(negedge clk);
        chk("lit.abandoned_write", 64'(ram[7]), 64'(shadow[7]));
        step();
        @(negedge clk);
        chk("lit.boot0_run", 64'(state), 64'd3);
        chk("lit.boot0_cpu_run", 64'(cpu_run), 64'd1);

        // Randomized traffic with occasional resets.
        for (int r = 0; r < 40; r++) begin
            rst = 1'b0; boot_mode = 1'($urandom);
            step(); step(); rst = 1'b1;
            pv = $urandom_range(90, 10);
            for (int c = 0; c < 120; c++) begin
                ld_valid   = ($urandom_range(99, 0) < pv);
                ld_addr    = AW'($urandom);
                ld_data    = $urandom;
                ld_last    = ($urandom_range(7, 0) == 0);
                if_req     = 1'($urandom);
                if_addr    = $urandom;
                reload_req = ($urandom_range(15, 0) == 0);
                boot_mode  = 1'($urandom);
                rst        = ($urandom_range(299, 0) != 0);
                step();
            end
        end
        rst = 1'b1; ld_valid = 1'b0; if_req = 1'b0; reload_req = 1'b0;
        step(); step();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
